// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the fetch stage: FSM state
//            encoding, default text-segment bounds, next-PC select codes and
//            the fetch-address legality check.
// Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

    // Default legal text segment (both bounds inclusive)
    localparam logic [31:0] DEF_TEXT_BASE  = 32'h0040_0000;
    localparam logic [31:0] DEF_TEXT_LIMIT = 32'h0FFF_FFFC;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    // Next-PC source select
    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    // An address is illegal when misaligned or outside [base, limit]
    function automatic logic pc_illegal(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] limit);
        return (addr[1:0] != 2'b00) || (addr < base) || (addr > limit);
    endfunction

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
// Module   : next_pc_calc
// Purpose  : Purely combinational next-PC selection (JR > J > branch > seq)
//            plus legality flag for the selected target.
// Revision : 1.0  initial release
// ============================================================================
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int          PC_W       = 32,
    parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
    parameter logic [31:0] TEXT_LIMIT = DEF_TEXT_LIMIT
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic            branch_taken_i,
    input  logic [15:0]     branch_offset_i,
    input  logic            jump_i,
    input  logic [25:0]     jump_target_i,
    input  logic            jump_reg_i,
    input  logic [PC_W-1:0] reg_target_i,
    output logic [PC_W-1:0] next_pc_o,
    output logic            illegal_o
);

    logic [PC_W-1:0] w_pc_plus4;
    logic [PC_W-1:0] w_br_disp;
    npc_sel_e        w_sel;

    assign w_pc_plus4 = pc_i + PC_W'(4);
    // Word offset sign-extended and scaled to bytes
    assign w_br_disp  = {{(PC_W-18){branch_offset_i[15]}}, branch_offset_i, 2'b00};

    // Resolve redirect priority into a single select code
    always_comb begin
        w_sel = NPC_SEQ;
        if (jump_reg_i)          w_sel = NPC_JR;
        else if (jump_i)         w_sel = NPC_J;
        else if (branch_taken_i) w_sel = NPC_BR;
    end

    // Form the selected target address
    always_comb begin
        next_pc_o = w_pc_plus4;
        case (w_sel)
            NPC_JR:  next_pc_o = reg_target_i;
            NPC_J:   next_pc_o = {w_pc_plus4[PC_W-1:PC_W-4], jump_target_i, 2'b00};
            NPC_BR:  next_pc_o = w_pc_plus4 + w_br_disp;
            default: next_pc_o = w_pc_plus4;
        endcase
    end

    assign illegal_o = pc_illegal(next_pc_o, TEXT_BASE, TEXT_LIMIT);

endmodule : next_pc_calc
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Program counter / instruction fetch stage. Boots from load_pc,
//            advances or redirects each cycle, freezes on stall, halt or an
//            illegal fetch address (sticky fault).
//            Optional: FETCH_COUNT_EN adds a 32-bit retired-fetch counter.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
    parameter logic [31:0] TEXT_LIMIT = DEF_TEXT_LIMIT,
    parameter int          PC_W       = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] load_pc,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [15:0]     branch_offset,
    input  logic            jump,
    input  logic [25:0]     jump_target,
    input  logic            jump_reg,
    input  logic [PC_W-1:0] reg_target,
    input  logic            halt_req,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            halted,
    output logic            fault
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]     fetch_count
`endif
);

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic            fault_q;
    logic [PC_W-1:0] w_next_pc;
    logic            w_next_illegal;
    logic            w_boot_illegal;

    next_pc_calc #(
        .PC_W       (PC_W),
        .TEXT_BASE  (TEXT_BASE),
        .TEXT_LIMIT (TEXT_LIMIT)
    ) u_next_pc_calc (
        .pc_i            (pc_q),
        .branch_taken_i  (branch_taken),
        .branch_offset_i (branch_offset),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .jump_reg_i      (jump_reg),
        .reg_target_i    (reg_target),
        .next_pc_o       (w_next_pc),
        .illegal_o       (w_next_illegal)
    );

    assign w_boot_illegal = pc_illegal(load_pc, TEXT_BASE, TEXT_LIMIT);

    // FSM, program counter and sticky fault flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            pc_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    // Boot PC is loaded even when it is illegal, for debug visibility
                    pc_q <= {load_pc[PC_W-1:2], 2'b00};
                    if (w_boot_illegal) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_q <= ST_HALT;
                    end else if (!stall) begin
                        pc_q <= {w_next_pc[PC_W-1:2], 2'b00};
                        if (w_next_illegal) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    // HALT and FAULT are terminal until reset
                    state_q <= state_q;
                end
            endcase
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q;

    // Count fetches that actually advance the PC out of RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= '0;
        end else if (state_q == ST_RUN && !stall && !halt_req) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

    assign pc          = pc_q;
    assign pc_plus4    = pc_q + PC_W'(4);
    assign fetch_valid = (state_q == ST_RUN);
    assign halted      = (state_q == ST_HALT) || (state_q == ST_FAULT);
    assign fault       = fault_q;

endmodule : fetch_unit
`default_nettype wire
